// File: rtl/multi_clk_divider.sv
// Bank of independent clock-enable generators. Each channel emits a one-cycle
// period strobe and a duty-controlled divided waveform from a runtime divisor/high time.
module multi_clk_divider #(
  parameter int N_CH      = 4,
  parameter int CTR_W     = 16,
  parameter int DIV_INIT  = 2,
  parameter int HIGH_INIT = 1,
  parameter int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  en,
  input  logic             align,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CTR_W-1:0] cfg_div,
  input  logic [CTR_W-1:0] cfg_high,
  output logic [N_CH-1:0]  cfg_pending,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  div_clk
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_e;

  localparam logic [CTR_W-1:0] ONE    = CTR_W'(1);
  localparam logic [CTR_W-1:0] D_RST  = CTR_W'(DIV_INIT);
  localparam logic [CTR_W-1:0] H_RST  = CTR_W'(HIGH_INIT);

  // Out-of-range channel numbers match no channel, so such writes are dropped.
  logic [31:0]     ch_idx;
  logic [N_CH-1:0] wr_sel;

  always_comb begin
    ch_idx = 32'(cfg_ch);
    wr_sel = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (cfg_we && (ch_idx == 32'(i))) begin
        wr_sel[i] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    run_state_e       state_q, state_d;
    logic [CTR_W-1:0] p_q, p_d;
    logic [CTR_W-1:0] div_q, div_d;
    logic [CTR_W-1:0] high_q, high_d;
    logic [CTR_W-1:0] sdiv_q, sdiv_d;
    logic [CTR_W-1:0] shigh_q, shigh_d;
    logic             pend_q, pend_d;
    logic             tick_q, tick_d;
    logic             dclk_q, dclk_d;
    logic             wrap;
    logic             apply;

    always_comb begin
      wrap    = (div_q == '0) || (p_q >= div_q - ONE);
      // Shadow moves to active only at a period boundary, using the shadow as
      // it stood before this edge; a same-edge write waits for the next boundary.
      apply   = pend_q && ((state_q == ST_IDLE) || (en[g] && (align || wrap)));
      div_d   = apply ? sdiv_q  : div_q;
      high_d  = apply ? shigh_q : high_q;
      sdiv_d  = wr_sel[g] ? cfg_div  : sdiv_q;
      shigh_d = wr_sel[g] ? cfg_high : shigh_q;
      pend_d  = wr_sel[g] || (pend_q && !apply);

      state_d = ST_IDLE;
      p_d     = '0;
      if (en[g] && (div_d != '0)) begin
        state_d = ST_RUN;
        if ((state_q == ST_RUN) && !align && !wrap) begin
          p_d = p_q + ONE;
        end
      end

      tick_d = (state_d == ST_RUN) && (p_d == '0);
      dclk_d = (state_d == ST_RUN) && (p_d < high_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ST_IDLE;
        p_q     <= '0;
        div_q   <= D_RST;
        high_q  <= H_RST;
        sdiv_q  <= '0;
        shigh_q <= '0;
        pend_q  <= 1'b0;
        tick_q  <= 1'b0;
        dclk_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        p_q     <= p_d;
        div_q   <= div_d;
        high_q  <= high_d;
        sdiv_q  <= sdiv_d;
        shigh_q <= shigh_d;
        pend_q  <= pend_d;
        tick_q  <= tick_d;
        dclk_q  <= dclk_d;
      end
    end

    assign cfg_pending[g] = pend_q;
    assign tick[g]        = tick_q;
    assign div_clk[g]     = dclk_q;
  end

endmodule

// File: doc/multi_clk_divider.md
Name: multi_clk_divider

Overview:
Parametrised successor to the single fixed-ratio divider. It provides N_CH independent clock-enable generators, each with a runtime-programmable divisor and high time, a per-channel enable, and a global phase-align input. Each channel outputs a one-cycle period strobe and a duty-controlled divided waveform. It sits between the system clock and the sampling, PWM and transducer timing logic, replacing per-use fixed dividers.

Parameters:
N_CH, 4, number of independent divider channels (>=1)
CTR_W, 16, width of the divisor, high-time and phase counters
DIV_INIT, 2, divisor loaded into every channel at reset
HIGH_INIT, 1, high time loaded into every channel at reset
CH_W, max(1,$clog2(N_CH)), channel-select width (derived)

Ports:
clk  in  1  system clock; all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
en  in  N_CH  per-channel run enable
align  in  1  single-cycle pulse that restarts all running channels at phase 0
cfg_we  in  1  config write strobe
cfg_ch  in  CH_W  channel addressed by the write
cfg_div  in  CTR_W  new divisor D
cfg_high  in  CTR_W  new high time H, in cycles
cfg_pending  out  N_CH  written config waiting for a period boundary
tick  out  N_CH  one-cycle strobe at phase 0 of each period
div_clk  out  N_CH  divided waveform, high for phases 0..H-1

Behaviour:
- Reset (rst_n=0, asynchronous): per channel active D=DIV_INIT, H=HIGH_INIT, shadow cleared, cfg_pending=0, running=0, phase p=0, tick=0, div_clk=0.
- All outputs are registered and there is no combinational input-to-output path.
- Per channel, the registers are running, phase p (CTR_W), active D/H, and shadow D/H with a pending flag.
- Run states:
  - IDLE (running=0): p held at 0, outputs 0.
  - Edge with en=1 and D!=0: go to RUN with p=0. tick and div_clk reflect p=0 in the next cycle.
  - So the first tick is visible one cycle after en is first sampled high.
- RUN, each edge: p <= (p>=D-1) ? 0 : p+1.
  - Registered outputs: tick <= (p_next==0); div_clk <= (p_next < H).
  - Period is D cycles, with exactly one tick per period.
  - div_clk is high H cycles per period.
  - H=0 gives div_clk constantly low. H>=D gives div_clk constantly high.
- D=1: tick is high every cycle while running.
- D=0: channel is halted. It stays in or returns to IDLE, with outputs 0 from the next cycle.
- en=0 sampled in RUN: go to IDLE, p=0, outputs 0 next cycle. A later re-enable starts a fresh phase 0; there is no phase memory.
- Config write:
  - On an edge with cfg_we=1 and cfg_ch<N_CH, cfg_div and cfg_high go to that channel's shadow and cfg_pending is set.
  - If cfg_ch>=N_CH the write is ignored.
  - A write while already pending overwrites the shadow; last write wins.
- Config apply:
  - If the channel is IDLE, the shadow is copied to active on the edge after the write, and pending clears.
  - If the channel is in RUN, the shadow is copied at the next wrap edge (p==D_old-1). The new period starts at p=0 with the new D/H, and pending clears.
  - A write on the same edge as a wrap is not applied at that wrap. It stays pending until the following wrap.
  - The current period is never truncated or extended by a config write.
- Shrinking D below the current p+1 cannot occur, because the apply happens only at the wrap.
- align=1 at an edge: every RUN channel sets p <= 0, loads any pending shadow, and shows tick=1 next cycle. IDLE channels are unaffected. align takes priority over a normal increment or wrap.
- Priority per channel per edge: rst_n > en=0 > D==0 halt > align > wrap/increment.
- Counter arithmetic is unsigned CTR_W-bit. p never exceeds max(D-1,0), so there is no overflow.

Test Plan:
- Reset with DIV_INIT=2, HIGH_INIT=1, en=1 on ch0 after release -> tick and div_clk on ch0 alternate 1,0,1,0 starting the cycle after en is sampled; all other channels stay 0; cfg_pending=0.
- Write ch1 D=5, H=2 while IDLE, then en[1]=1 -> cfg_pending[1] clears the next cycle; tick[1] has period 5; div_clk[1] pattern 1,1,0,0,0 repeating.
- ch1 running D=5; write D=3, H=1 at p=2 -> the period finishes at 5 cycles and cfg_pending[1]=1 until the wrap; then period 3 with div_clk 1,0,0; one more write landing on a wrap edge stays pending one more period.
- ch0 D=4 and ch2 D=6 running out of phase; pulse align -> both show tick=1 the next cycle, then periods 4 and 6 from a common phase; an IDLE ch3 stays 0.
- Edge cases: D=1 -> tick constantly 1; D=0 written to a running channel -> outputs 0 after the wrap apply; H=7 with D=4 -> div_clk constantly 1; cfg_ch=N_CH -> no state change.
- Deassert en mid-period, and assert rst_n=0 between clock edges mid-period -> outputs 0 (reset immediately, asynchronously); re-enable restarts at phase 0 with an unchanged D/H, or DIV_INIT/HIGH_INIT after reset.
